// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encoding.
package nsa_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational (zero latency, no handshake).
// c3 is the carry into bit 3, so the caller can form signed overflow as cout ^ c3.
module cla4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);
  logic [NIBBLE_W-1:0] g, p;
  logic                c1, c2;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded fully from g/p and cin, not rippled.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract, one nibble per cycle LSB first; result valid WIDTH/4 cycles after accept.
// Accepts only in IDLE; result is held in DONE until out_ready, so the source stalls meanwhile.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH-1:0]    a_sh, b_sh;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout, slice_c3;

  assign a_sh = a_q >> (int'(cnt_q) * NIBBLE_W);
  assign b_sh = b_q >> (int'(cnt_q) * NIBBLE_W);

  cla4_slice u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is A + ~B + 1; a borrow-in cancels the +1.
          a_d     = in_a;
          b_d     = in_b ^ {WIDTH{in_sub}};
          carry_d = in_cin ^ in_sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        sum_d[int'(cnt_q)*NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_cout;
        if (cnt_q == CW'(NIB - 1)) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_c3;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;
endmodule
